// File: rtl/uart_pkt_payload_extractor.sv
// uart_pkt_payload_extractor
//   Frames raw UART RX bytes (AA 55 LEN_H LEN_L payload [CHK]) into packets and
//   forwards only the payload on a valid/ready/last stream through a small FIFO.
//   Per-packet completion is reported on pkt_done / pkt_err / err_code / pkt_len.
//   Optional feature macro: PKT_CHECKSUM_EN (adds the trailing checksum byte).
module uart_pkt_payload_extractor #(
    parameter int MAX_PAYLOAD    = 2048,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  pkt_payload_data,
    output logic        pkt_payload_valid,
    output logic        pkt_payload_last,
    input  logic        pkt_payload_ready,
    output logic        busy,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [2:0]  err_code,
    output logic [15:0] pkt_len
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_LENGTH   = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHK
    } state_t;

    state_t state_reg, state_next;
    logic [15:0] len_reg, len_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        ovf_reg, ovf_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic [2:0]  code_reg, code_next;
    logic [15:0] pkt_len_reg, pkt_len_next;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]  sum_reg, sum_next;
`endif

    // Payload FIFO: pointers carry one extra wrap bit so full/empty are unambiguous.
    logic [8:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] fifo_count;
    logic        fifo_full, fifo_empty, fifo_pop, can_push, fifo_push;
    logic        push_req, push_last;
    logic [8:0]  fifo_head;
    logic [15:0] len_val;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_pop   = !fifo_empty && pkt_payload_ready;
    // A pop in the same cycle frees a slot, so a write at full still succeeds.
    assign can_push   = !fifo_full || fifo_pop;
    assign fifo_push  = push_req && can_push;
    assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign len_val    = {len_reg[15:8], rx_data};

    assign pkt_payload_valid = !fifo_empty;
    assign pkt_payload_data  = fifo_empty ? 8'd0 : fifo_head[7:0];
    assign pkt_payload_last  = !fifo_empty && fifo_head[8];
    assign busy      = (state_reg != S_IDLE) || !fifo_empty;
    assign pkt_done  = done_reg;
    assign pkt_err   = err_reg;
    assign err_code  = code_reg;
    assign pkt_len   = pkt_len_reg;

    // FIFO storage write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_reg[AW-1:0]] <= {push_last, rx_data};
    end

    // FIFO pointers; reset flushes the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Parser state and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            len_reg     <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            tmo_reg     <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            code_reg    <= ERR_NONE;
            pkt_len_reg <= '0;
`ifdef PKT_CHECKSUM_EN
            sum_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
            tmo_reg     <= tmo_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            code_reg    <= code_next;
            pkt_len_reg <= pkt_len_next;
`ifdef PKT_CHECKSUM_EN
            sum_reg     <= sum_next;
`endif
        end
    end

    // Next-state logic: one transition per received byte, plus the idle timeout.
    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        cnt_next     = cnt_reg;
        ovf_next     = ovf_reg;
        tmo_next     = '0;
        done_next    = 1'b0;
        err_next     = err_reg;
        code_next    = code_reg;
        pkt_len_next = pkt_len_reg;
        push_req     = 1'b0;
        push_last    = 1'b0;
`ifdef PKT_CHECKSUM_EN
        sum_next     = sum_reg;
`endif
        if (state_reg != S_IDLE && !rx_valid) tmo_next = tmo_reg + 1'b1;

        if (rx_valid) begin
            case (state_reg)
                S_IDLE: if (rx_data == 8'hAA) state_next = S_SYNC;
                S_SYNC: begin
                    if (rx_data == 8'h55)      state_next = S_LEN_H;
                    else if (rx_data != 8'hAA) state_next = S_IDLE;
                end
                S_LEN_H: begin
                    len_next   = {rx_data, 8'h00};
                    state_next = S_LEN_L;
                end
                S_LEN_L: begin
                    len_next = len_val;
                    if (len_val == 16'd0 || {16'd0, len_val} > 32'(MAX_PAYLOAD)) begin
                        done_next    = 1'b1;
                        err_next     = 1'b1;
                        code_next    = ERR_LENGTH;
                        pkt_len_next = len_val;
                        state_next   = S_IDLE;
                    end else begin
                        cnt_next   = len_val;
                        ovf_next   = 1'b0;
`ifdef PKT_CHECKSUM_EN
                        sum_next   = '0;
`endif
                        state_next = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    push_req  = 1'b1;
                    push_last = (cnt_reg == 16'd1);
                    if (!can_push) ovf_next = 1'b1;
                    cnt_next  = cnt_reg - 1'b1;
`ifdef PKT_CHECKSUM_EN
                    sum_next  = sum_reg + rx_data;
                    if (cnt_reg == 16'd1) state_next = S_CHK;
`else
                    if (cnt_reg == 16'd1) begin
                        done_next    = 1'b1;
                        err_next     = ovf_reg || !can_push;
                        code_next    = (ovf_reg || !can_push) ? ERR_OVERFLOW : ERR_NONE;
                        pkt_len_next = len_reg;
                        state_next   = S_IDLE;
                    end
`endif
                end
                S_CHK: begin
                    done_next    = 1'b1;
                    pkt_len_next = len_reg;
                    state_next   = S_IDLE;
`ifdef PKT_CHECKSUM_EN
                    if (ovf_reg)                  code_next = ERR_OVERFLOW;
                    else if (rx_data != sum_reg)  code_next = 3'd2;
                    else                          code_next = ERR_NONE;
                    err_next = ovf_reg || (rx_data != sum_reg);
`else
                    err_next  = ovf_reg;
                    code_next = ovf_reg ? ERR_OVERFLOW : ERR_NONE;
`endif
                end
                default: state_next = S_IDLE;
            endcase
        end else if (state_reg != S_IDLE && tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Line went quiet mid-packet; anything already buffered still drains.
            done_next    = 1'b1;
            err_next     = 1'b1;
            code_next    = ERR_TIMEOUT;
            pkt_len_next = len_reg;
            tmo_next     = '0;
            state_next   = S_IDLE;
        end
    end
endmodule

// File: tb/tb_uart_pkt_payload_extractor.sv
// Directed testbench for uart_pkt_payload_extractor (works with or without PKT_CHECKSUM_EN).
module tb_uart_pkt_payload_extractor;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  pkt_payload_data;
    logic        pkt_payload_valid;
    logic        pkt_payload_last;
    logic        pkt_payload_ready = 1'b1;
    logic        busy;
    logic        pkt_done;
    logic        pkt_err;
    logic [2:0]  err_code;
    logic [15:0] pkt_len;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]  byte_q [$];   // {last, data} of each accepted output byte
    logic [19:0] done_q [$];   // {err, code, len} of each done pulse

    uart_pkt_payload_extractor #(.MAX_PAYLOAD(2048), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkt_payload_data(pkt_payload_data), .pkt_payload_valid(pkt_payload_valid),
        .pkt_payload_last(pkt_payload_last), .pkt_payload_ready(pkt_payload_ready),
        .busy(busy), .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code),
        .pkt_len(pkt_len)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge sees exactly what the next posedge will.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_payload_valid && pkt_payload_ready)
                byte_q.push_back({pkt_payload_last, pkt_payload_data});
            if (pkt_done)
                done_q.push_back({pkt_err, err_code, pkt_len});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] len);
        send_byte(8'hAA); send_byte(8'h55); send_byte(len[15:8]); send_byte(len[7:0]);
    endtask

    task automatic clear_q;
        byte_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        n_cmp++;
        if ({pkt_payload_data, pkt_payload_valid, pkt_payload_last, busy, pkt_done, pkt_err, err_code, pkt_len} !== 31'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%h v=%b l=%b busy=%b done=%b err=%b code=%0d len=%0d, want all 0",
                     pkt_payload_data, pkt_payload_valid, pkt_payload_last, busy, pkt_done, pkt_err, err_code, pkt_len);
        end
        rst = 1'b0;
        tick(2);
        $display("test_reset: outputs checked under reset");
    endtask

    // "123 456 789"; mod-256 sum = 0x1D
    task automatic test_frame_ok(input bit bad_chk);
        logic [7:0] pl [11];
        logic [7:0] chk;
        logic [19:0] exp_done;
        pl = '{8'h31, 8'h32, 8'h33, 8'h20, 8'h34, 8'h35, 8'h36, 8'h20, 8'h37, 8'h38, 8'h39};
        chk = bad_chk ? 8'h00 : 8'h1D;
        clear_q();
        pkt_payload_ready = 1'b1;
        send_hdr(16'd11);
        for (int i = 0; i < 11; i++) send_byte(pl[i]);
`ifdef PKT_CHECKSUM_EN
        send_byte(chk);
        exp_done = bad_chk ? {1'b1, 3'd2, 16'd11} : {1'b0, 3'd0, 16'd11};
`else
        exp_done = {1'b0, 3'd0, 16'd11};
`endif
        n_cmp++;
        if (pkt_done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_latency: pkt_done=%b one cycle after final byte, want 1", pkt_done);
        end
        tick(5);
        n_cmp++;
        if (byte_q.size() != 11) begin
            n_bad++;
            $display("FAIL frame_count: got %0d bytes, want 11", byte_q.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_cmp++;
                if (byte_q[i] !== {(i == 10), pl[i]}) begin
                    n_bad++;
                    $display("FAIL frame_byte%0d: got %h, want %h", i, byte_q[i], {(i == 10), pl[i]});
                end
            end
        end
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] !== exp_done) begin
            n_bad++;
            $display("FAIL frame_done: got %0d pulses first=%h, want 1 pulse %h",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : 20'h0, exp_done);
        end
        $display("test_frame_ok(bad_chk=%0d): %0d bytes, %0d done", bad_chk, byte_q.size(), done_q.size());
    endtask

    task automatic test_bad_len;
        clear_q();
        send_hdr(16'h0000);
        send_hdr(16'h0FFF);
        tick(3);
        n_cmp++;
        if (done_q.size() != 2 || done_q[0] !== {1'b1, 3'd1, 16'h0000} || done_q[1] !== {1'b1, 3'd1, 16'h0FFF}) begin
            n_bad++;
            $display("FAIL bad_len_done: got %0d pulses, want 2 with code 1 (len 0, 4095)", done_q.size());
        end
        n_cmp++;
        if (byte_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_len_payload: got %0d bytes busy=%b, want 0 bytes busy=0", byte_q.size(), busy);
        end
        $display("test_bad_len: %0d done pulses", done_q.size());
    endtask

    task automatic test_overflow;
        clear_q();
        pkt_payload_ready = 1'b0;
        send_hdr(16'd32);
        for (int i = 0; i < 32; i++) send_byte(8'h41 + 8'(i));
`ifdef PKT_CHECKSUM_EN
        send_byte(8'h00);
`endif
        tick(2);
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] !== {1'b1, 3'd4, 16'd32}) begin
            n_bad++;
            $display("FAIL overflow_done: got %0d pulses first=%h, want %h", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : 20'h0, {1'b1, 3'd4, 16'd32});
        end
        n_cmp++;
        if (pkt_payload_valid !== 1'b1 || pkt_payload_data !== 8'h41) begin
            n_bad++;
            $display("FAIL overflow_hold: valid=%b data=%h, want valid=1 data=41", pkt_payload_valid, pkt_payload_data);
        end
        pkt_payload_ready = 1'b1;
        tick(24);
        n_cmp++;
        if (byte_q.size() != 16) begin
            n_bad++;
            $display("FAIL overflow_drain: got %0d bytes, want 16", byte_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (byte_q[i] !== {1'b0, 8'h41 + 8'(i)}) begin
                    n_bad++;
                    $display("FAIL overflow_byte%0d: got %h, want %h", i, byte_q[i], {1'b0, 8'h41 + 8'(i)});
                end
            end
        end
        $display("test_overflow: drained %0d bytes", byte_q.size());
    endtask

    task automatic test_timeout;
        int waited;
        clear_q();
        pkt_payload_ready = 1'b1;
        send_hdr(16'd5);
        send_byte(8'h31);
        send_byte(8'h32);
        waited = 0;
        while (done_q.size() == 0 && waited < 4 * TMO) begin
            tick(1);
            waited++;
        end
        tick(3);
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] !== {1'b1, 3'd3, 16'd5}) begin
            n_bad++;
            $display("FAIL timeout_done: got %0d pulses after %0d cycles, want 1 with code 3", done_q.size(), waited);
        end
        n_cmp++;
        if (byte_q.size() != 2 || byte_q[0] !== 9'h031 || byte_q[1] !== 9'h032 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_drain: got %0d bytes busy=%b, want 031 032 and busy=0", byte_q.size(), busy);
        end
        $display("test_timeout: done after %0d idle cycles", waited);
    endtask

    task automatic test_back_to_back;
        clear_q();
        pkt_payload_ready = 1'b1;
        send_hdr(16'd2); send_byte(8'h41); send_byte(8'h42);
`ifdef PKT_CHECKSUM_EN
        send_byte(8'h83);
`endif
        send_hdr(16'd1); send_byte(8'h43);
`ifdef PKT_CHECKSUM_EN
        send_byte(8'h43);
`endif
        tick(4);
        n_cmp++;
        if (byte_q.size() != 3 || byte_q[0] !== 9'h041 || byte_q[1] !== 9'h142 || byte_q[2] !== 9'h143) begin
            n_bad++;
            $display("FAIL b2b_bytes: got %0d bytes, want 041 142 143", byte_q.size());
        end
        n_cmp++;
        if (done_q.size() != 2 || done_q[0] !== {1'b0, 3'd0, 16'd2} || done_q[1] !== {1'b0, 3'd0, 16'd1}) begin
            n_bad++;
            $display("FAIL b2b_done: got %0d pulses, want 2 good (len 2, 1)", done_q.size());
        end
        $display("test_back_to_back: %0d bytes, %0d done", byte_q.size(), done_q.size());
    endtask

    task automatic test_noise_and_reset;
        clear_q();
        pkt_payload_ready = 1'b1;
        send_byte(8'h13); send_byte(8'hAA);
        send_hdr(16'd1); send_byte(8'h37);
`ifdef PKT_CHECKSUM_EN
        send_byte(8'h37);
`endif
        tick(4);
        n_cmp++;
        if (byte_q.size() != 1 || byte_q[0] !== 9'h137 || done_q.size() != 1 || done_q[0] !== {1'b0, 3'd0, 16'd1}) begin
            n_bad++;
            $display("FAIL noise_frame: got %0d bytes %0d done, want byte 137 and one good done", byte_q.size(), done_q.size());
        end
        clear_q();
        pkt_payload_ready = 1'b0;
        send_hdr(16'd5); send_byte(8'h31); send_byte(8'h32);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pkt_payload_data, pkt_payload_valid, pkt_payload_last, busy, pkt_done, pkt_err, err_code, pkt_len} !== 31'd0) begin
            n_bad++;
            $display("FAIL midpkt_reset: got data=%h v=%b busy=%b done=%b code=%0d len=%0d, want all 0",
                     pkt_payload_data, pkt_payload_valid, busy, pkt_done, err_code, pkt_len);
        end
        tick(2);
        rst = 1'b0;
        pkt_payload_ready = 1'b1;
        tick(5);
        n_cmp++;
        if (byte_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: got %0d bytes %0d done busy=%b, want none and busy=0", byte_q.size(), done_q.size(), busy);
        end
        $display("test_noise_and_reset: reset mid-payload checked");
    endtask

    initial begin
        test_reset();
        test_frame_ok(1'b0);
        test_frame_ok(1'b1);
        test_bad_len();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_noise_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end
endmodule
